// File: rtl/fft_result_streamer.sv
// FFT result streamer: reads the N transform outputs from the final ping-pong
// bank through a synchronous-read port and streams them in natural frequency
// order on a valid/ready interface. A 2-entry skid FIFO plus the single
// in-flight read bound the buffered words to two.
module fft_result_streamer #(
  parameter int MAX_N       = 32,
  parameter int ADDR_WIDTH  = $clog2(MAX_N),
  parameter int DATA_WIDTH  = 32,
  parameter bit READ_BITREV = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  final_bank,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state, state_next;

  // Counters carry one extra bit so that EFFECTIVE_N itself is representable.
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [ADDR_WIDTH:0]   out_cnt;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_idx;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_idx  [2];
  logic                  fifo_rd_ptr;
  logic                  fifo_wr_ptr;
  logic [1:0]            fifo_count;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] rd_idx_rev;
  logic [1:0]            occupancy;
  logic                  start_ok;
  logic                  pop;
  logic                  fifo_pop;
  logic                  push;
  logic                  last_pop;

  // Read issue control and address generation (natural or bit-reversed).
  always_comb begin
    rd_idx     = rd_cnt[ADDR_WIDTH-1:0];
    rd_idx_rev = '0;
    for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
      rd_idx_rev[i] = rd_idx[ADDR_WIDTH-1-i];
    end
    busy      = (state == STREAM);
    start_ok  = (state == IDLE) && start;
    occupancy = fifo_count + {1'b0, inflight};
    rd_en     = busy && !rd_cnt[ADDR_WIDTH] && (occupancy < 2'd2);
    rd_addr   = READ_BITREV ? rd_idx_rev : rd_idx;
  end

  // Output head: an empty FIFO is bypassed by the returning read so the first
  // word appears in the same cycle its data comes back from memory.
  always_comb begin
    m_valid = (fifo_count != 2'd0) || inflight;
    m_data  = '0;
    m_index = '0;
    if (fifo_count != 2'd0) begin
      m_data  = fifo_data[fifo_rd_ptr];
      m_index = fifo_idx[fifo_rd_ptr];
    end else if (inflight) begin
      m_data  = rd_data;
      m_index = inflight_idx;
    end
    m_last   = m_valid && (m_index == LAST_IDX);
    pop      = m_valid && m_ready;
    fifo_pop = pop && (fifo_count != 2'd0);
    // A returning word is stored unless it leaves straight through the bypass.
    push     = inflight && !((fifo_count == 2'd0) && pop);
    last_pop = pop && (out_cnt == {1'b0, LAST_IDX});
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = STREAM;
      STREAM:  if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, in-flight tracking, skid FIFO and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank      <= 1'b0;
      rd_cnt       <= '0;
      out_cnt      <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      fifo_rd_ptr  <= 1'b0;
      fifo_wr_ptr  <= 1'b0;
      fifo_count   <= '0;
      done         <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
      end
    end else begin
      done     <= last_pop;
      inflight <= rd_en;
      if (rd_en) inflight_idx <= rd_idx;
      if (start_ok) begin
        rd_bank <= final_bank;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt  <= rd_cnt + 1'b1;
        if (pop)   out_cnt <= out_cnt + 1'b1;
      end
      if (push) begin
        fifo_data[fifo_wr_ptr] <= rd_data;
        fifo_idx[fifo_wr_ptr]  <= inflight_idx;
        fifo_wr_ptr            <= ~fifo_wr_ptr;
      end
      if (fifo_pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: three instances (natural N=32, bit-reversed
// N=32, natural N=8) with a behavioural memory each; expected streams come
// from the memory contents and the natural/bit-reversed address rule.
module tb_fft_result_streamer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start      [3];
  logic        final_bank [3];
  logic        m_ready    [3];
  logic        rd_en      [3];
  logic        rd_bank    [3];
  logic        m_valid    [3];
  logic        m_last     [3];
  logic        busy       [3];
  logic        done       [3];
  logic [31:0] rd_data    [3];
  logic [31:0] m_data     [3];
  logic [4:0]  rd_addr    [3];
  logic [4:0]  m_index    [3];
  logic [2:0]  rd_addr_c;
  logic [2:0]  m_index_c;
  assign rd_addr[2] = {2'b00, rd_addr_c};
  assign m_index[2] = {2'b00, m_index_c};

  logic [31:0] mem [3][2][32];

  int checks = 0;
  int errors = 0;

  fft_result_streamer #(.MAX_N(32), .DATA_WIDTH(32), .READ_BITREV(1'b0)) dut_nat (
    .clk(clk), .reset(reset), .start(start[0]), .final_bank(final_bank[0]),
    .rd_en(rd_en[0]), .rd_bank(rd_bank[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_index(m_index[0]),
    .m_last(m_last[0]), .busy(busy[0]), .done(done[0]));

  fft_result_streamer #(.MAX_N(32), .DATA_WIDTH(32), .READ_BITREV(1'b1)) dut_rev (
    .clk(clk), .reset(reset), .start(start[1]), .final_bank(final_bank[1]),
    .rd_en(rd_en[1]), .rd_bank(rd_bank[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_index(m_index[1]),
    .m_last(m_last[1]), .busy(busy[1]), .done(done[1]));

  fft_result_streamer #(.MAX_N(8), .DATA_WIDTH(32), .READ_BITREV(1'b0)) dut_small (
    .clk(clk), .reset(reset), .start(start[2]), .final_bank(final_bank[2]),
    .rd_en(rd_en[2]), .rd_bank(rd_bank[2]), .rd_addr(rd_addr_c), .rd_data(rd_data[2]),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_index(m_index_c),
    .m_last(m_last[2]), .busy(busy[2]), .done(done[2]));

  // Synchronous-read memories: data is valid the cycle after rd_en.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k] === 1'b1) rd_data[k] <= mem[k][rd_bank[k]][rd_addr[k]];
    end
  end

  function automatic int n_of(input int k);
    return (k == 2) ? 8 : 32;
  endfunction

  function automatic int w_of(input int k);
    return (k == 2) ? 3 : 5;
  endfunction

  function automatic int rev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = r | (1 << (w - 1 - i));
    return r;
  endfunction

  // Memory address holding natural-order bin i.
  function automatic int addr_of(input int k, input int i);
    return (k == 1) ? rev(i, w_of(k)) : i;
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       case (cyc % 4) 0, 3: r = 1'b1; default: r = 1'b0; endcase
      default: r = 1'($urandom_range(0, 1));
    endcase
    return r;
  endfunction

  // fmode 0: bank1 word[i]=i+0x100, bank0 random; 1: random; 2: word[a]=a.
  task automatic fill(input int k, input int fmode);
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++)
        case (fmode)
          0:       mem[k][b][a] = (b == 1) ? 32'(a + 'h100) : $urandom;
          2:       mem[k][b][a] = 32'(a);
          default: mem[k][b][a] = $urandom;
        endcase
  endtask

  // One unload: drives start, follows the stream cycle by cycle, checks it.
  task automatic unload(input int k, input bit bank, input int mode, input bit no_wait,
                        input int spur_at, input int abort_at, input bit chain);
    int n, xfers, issued, cyc, first_valid, last_xfer_cyc;
    bit fin, prev_stall, spur_done, aborted;
    logic [31:0] pd, exp_d;
    logic [4:0]  pi;
    logic        pl;
    n = n_of(k);
    xfers = 0; issued = 0; cyc = 0; first_valid = -1; last_xfer_cyc = -10;
    fin = 0; prev_stall = 0; spur_done = 0; aborted = 0;
    if (!no_wait) @(negedge clk);
    start[k] = 1'b1;
    final_bank[k] = bank;
    m_ready[k] = ready_for(mode, 0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start[k] = 1'b0;
      if (spur_at >= 0 && xfers == spur_at && !spur_done) begin
        start[k] = 1'b1;
        final_bank[k] = ~bank;
        spur_done = 1;
      end
      if (abort_at >= 0 && xfers >= abort_at) m_ready[k] = 1'b0;
      else m_ready[k] = ready_for(mode, cyc);
      if (prev_stall) begin
        checks++;
        if (m_valid[k] !== 1'b1 || m_data[k] !== pd || m_index[k] !== pi || m_last[k] !== pl) begin
          errors++;
          $display("FAIL stall_hold k=%0d cyc=%0d: got v=%b d=%h i=%0d l=%b, need v=1 d=%h i=%0d l=%b",
                   k, cyc, m_valid[k], m_data[k], m_index[k], m_last[k], pd, pi, pl);
        end
      end
      if (cyc == 1) begin
        checks++;
        if (rd_en[k] !== 1'b1 || m_valid[k] !== 1'b0 || busy[k] !== 1'b1) begin
          errors++;
          $display("FAIL first_cycle k=%0d: got rd_en=%b m_valid=%b busy=%b, need 1 0 1",
                   k, rd_en[k], m_valid[k], busy[k]);
        end
      end
      if (busy[k] === 1'b1) begin
        checks++;
        if (rd_bank[k] !== bank) begin
          errors++;
          $display("FAIL rd_bank k=%0d cyc=%0d: got %b need %b", k, cyc, rd_bank[k], bank);
        end
      end
      if (rd_en[k] === 1'b1) begin
        checks++;
        if (issued - xfers >= 2 || issued >= n || rd_addr[k] !== 5'(addr_of(k, issued))) begin
          errors++;
          $display("FAIL read_issue k=%0d cyc=%0d: got addr=%0d outstanding=%0d issued=%0d, need addr=%0d outstanding<2 issued<%0d",
                   k, cyc, rd_addr[k], issued - xfers, issued, addr_of(k, issued), n);
        end
        issued++;
      end
      if (m_valid[k] === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        if (m_ready[k] === 1'b1) begin
          exp_d = mem[k][bank][addr_of(k, xfers)];
          checks++;
          if (m_data[k] !== exp_d || m_index[k] !== 5'(xfers) || m_last[k] !== (xfers == n - 1)) begin
            errors++;
            $display("FAIL word k=%0d n=%0d: got d=%h i=%0d l=%b, need d=%h i=%0d l=%b",
                     k, xfers, m_data[k], m_index[k], m_last[k], exp_d, xfers, (xfers == n - 1));
          end
          last_xfer_cyc = cyc;
          xfers++;
        end
      end
      if (done[k] === 1'b1) begin
        checks++;
        if (xfers != n || cyc != last_xfer_cyc + 1 || busy[k] !== 1'b0 || m_valid[k] !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse k=%0d: got words=%0d gap=%0d busy=%b m_valid=%b, need words=%0d gap=1 busy=0 m_valid=0",
                   k, xfers, cyc - last_xfer_cyc, busy[k], m_valid[k], n);
        end
        fin = 1;
      end
      prev_stall = (m_valid[k] === 1'b1) && (m_ready[k] !== 1'b1);
      pd = m_data[k]; pi = m_index[k]; pl = m_last[k];
      if (abort_at >= 0 && xfers >= abort_at && cyc >= last_xfer_cyc + 3) begin
        fin = 1; aborted = 1;
      end
      if (!fin && cyc > 3000) begin
        checks++; errors++;
        $display("FAIL timeout k=%0d: got %0d words, need %0d with done", k, xfers, n);
        fin = 1; aborted = 1;
      end
    end
    if (aborted) return;
    checks++;
    if (first_valid != 2) begin
      errors++;
      $display("FAIL first_valid_latency k=%0d: got %0d need 2", k, first_valid);
    end
    if (mode == 0) begin
      checks++;
      if (last_xfer_cyc != n + 1) begin
        errors++;
        $display("FAIL last_word_cycle k=%0d: got %0d need %0d", k, last_xfer_cyc, n + 1);
      end
    end
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (done[k] !== 1'b0 || busy[k] !== 1'b0 || m_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL after_done k=%0d: got done=%b busy=%b m_valid=%b, need 0 0 0",
                 k, done[k], busy[k], m_valid[k]);
      end
    end
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_en[k] !== 1'b0 || rd_bank[k] !== 1'b0 || rd_addr[k] !== 5'd0 || m_valid[k] !== 1'b0 ||
          m_data[k] !== 32'd0 || m_index[k] !== 5'd0 || m_last[k] !== 1'b0 || busy[k] !== 1'b0 ||
          done[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state k=%0d: got rd_en=%b bank=%b addr=%0d v=%b d=%h i=%0d l=%b busy=%b done=%b, need all 0",
                 k, rd_en[k], rd_bank[k], rd_addr[k], m_valid[k], m_data[k], m_index[k], m_last[k], busy[k], done[k]);
      end
    end
  endtask

  task automatic test_stream_ready_high;
    fill(0, 0);
    unload(0, 1'b1, 0, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_backpressure;
    unload(0, 1'b1, 1, 1'b0, -1, -1, 1'b0);
    unload(0, 1'b1, 2, 1'b0, -1, -1, 1'b0);
    fill(0, 1);
    unload(0, 1'b0, 2, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_bitrev;
    fill(1, 2);
    unload(1, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    fill(1, 1);
    unload(1, 1'b1, 2, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_ignored_start;
    fill(0, 1);
    unload(0, 1'b1, 2, 1'b0, 10, -1, 1'b0);
    unload(0, 1'b0, 0, 1'b0, 10, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    fill(0, 1);
    unload(0, 1'b0, 0, 1'b0, -1, -1, 1'b1);
    unload(0, 1'b1, 2, 1'b1, -1, -1, 1'b0);
  endtask

  task automatic test_reset_midstream;
    fill(0, 0);
    unload(0, 1'b1, 0, 1'b0, -1, 17, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid[0] !== 1'b0 || busy[0] !== 1'b0 || rd_en[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got m_valid=%b busy=%b rd_en=%b done=%b, need 0 0 0 0",
               m_valid[0], busy[0], rd_en[0], done[0]);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got m_valid=%b busy=%b, need 0 0", m_valid[0], busy[0]);
    end
    fill(0, 1);
    unload(0, 1'b0, 2, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_small;
    fill(2, 1);
    unload(2, 1'b0, 0, 1'b0, -1, -1, 1'b0);
    unload(2, 1'b0, 2, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; final_bank[k] = 1'b0; m_ready[k] = 1'b0; rd_data[k] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b1;
    @(negedge clk);
    test_stream_ready_high;
    test_backpressure;
    test_bitrev;
    test_ignored_start;
    test_back_to_back;
    test_reset_midstream;
    test_small;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_result_streamer.md
Name: fft_result_streamer

Overview:
- Read-side counterpart to the FFT input loader and DIT AGU.
- After the core raises done_fft, this block reads the N results from the final ping-pong bank through a synchronous-read memory port and streams them out on a valid/ready interface.
- Stream is natural frequency order, with index and last markers.
- A 2-entry output skid buffer absorbs the 1-cycle memory read latency under backpressure.

Parameters:
- MAX_N, 32, transform length; rounded internally to EFFECTIVE_N = 1 << $clog2(MAX_N).
- ADDR_WIDTH, $clog2(MAX_N), memory address and index width.
- DATA_WIDTH, 32, complex word width (real in upper half, imag in lower half); passed through untouched.
- READ_BITREV, 0, when 1 rd_addr is the bit-reversed count. Used for builds whose memory holds results in bit-reversed order.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse (driven from done_fft); begins an unload
- final_bank  in  1  bank holding the results; sampled on accepted start
- rd_en  out  1  memory read strobe
- rd_bank  out  1  bank select for the read, held for the whole unload
- rd_addr  out  ADDR_WIDTH  memory read address
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
- m_valid  out  1  output word valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  output word
- m_index  out  ADDR_WIDTH  natural-order bin index of m_data
- m_last  out  1  high with the word whose m_index = EFFECTIVE_N-1
- busy  out  1  unload in progress
- done  out  1  single-cycle pulse after the final word is accepted

Behaviour:
- Reset (async, active-low):
  - State IDLE.
  - rd_en=0, rd_bank=0, rd_addr=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0.
  - Skid buffer and all counters cleared.
  - Reset mid-unload aborts immediately; no partial words appear after reset release.
- State IDLE:
  - start with busy=0 is accepted: latch final_bank into rd_bank, rd_cnt=0, out_cnt=0, busy=1, go to STREAM.
  - start is accepted even in the cycle done is high.
- State STREAM:
  - rd_en=1 when rd_cnt < EFFECTIVE_N and (fifo_count + inflight) < 2, where inflight = rd_en registered from the previous cycle.
  - rd_addr = rd_cnt, or bitrev(rd_cnt) when READ_BITREV=1. rd_cnt increments per issued read.
  - Returned rd_data is pushed into the skid FIFO together with its index; index = the rd_cnt value at issue.
  - FIFO head drives m_valid, m_data, m_index, m_last.
  - Handshake: a word transfers when m_valid && m_ready.
    - m_data, m_index and m_last hold stable while m_valid=1 and m_ready=0.
    - m_valid never drops without a transfer.
  - out_cnt increments per transfer. After the transfer with out_cnt = EFFECTIVE_N-1, go to IDLE: busy=0 and done=1 for exactly one cycle.
- Latency: start accepted at cycle T → first rd_en at T+1 → first m_valid at T+2.
  - With m_ready held high: one word per cycle, last word at T+EFFECTIVE_N+1, done at T+EFFECTIVE_N+2.
- Backpressure: never more than 2 words are buffered or in flight. No word is lost or duplicated under any m_ready pattern.
- start while busy=1 is ignored; the unload in progress is unaffected.
- Counters are ADDR_WIDTH+1 bits so EFFECTIVE_N is representable; addresses use the low ADDR_WIDTH bits.
- Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.

Test Plan:
- Memory preloaded with word[i]=i+0x100 in bank 1, final_bank=1, start pulse, m_ready=1 → 32 words 0x100..0x11F, m_index 0..31, rd_bank=1 throughout, m_last only on index 31, done one cycle after the last word, first m_valid 2 cycles after start.
- m_ready toggled 1,0,0,1 repeatedly and randomly → identical ordered sequence as the previous case. Data stable during stalls; rd_en never issued while buffer+inflight=2.
- READ_BITREV=1, memory word[a]=a → rd_addr sequence 0,16,8,24,4...; m_data equals bitrev(m_index) for every output.
- Second start pulse at word 10 of an unload → ignored; exactly 32 words and one done pulse. A start in the done cycle begins a new unload with first m_valid 2 cycles later.
- reset asserted at word 17 with m_ready=0 → m_valid=0, busy=0 and rd_en=0 immediately. After release, start gives a clean unload beginning at index 0.
- MAX_N=8, final_bank=0 → exactly 8 words, m_last on index 7, rd_addr never exceeds 7.
